// File: rtl/axis_width_down.sv
// axis_width_down
//   AXI-Stream width downsizer. Each accepted wide input word
//   (M_DATA_BITS*RATIO bits) is emitted as RATIO narrow beats, one per cycle
//   while downstream is ready. Holds at most one wide word; the next word is
//   accepted on the same cycle the final beat of the current word leaves, so
//   consecutive words drain without a bubble.
//
// Parameters
//   M_DATA_BITS  width of one output beat
//   RATIO        output beats per input word (>= 1)
//   LSB_FIRST    1: slice 0 (bits M_DATA_BITS-1:0) first; 0: top slice first
//
// Ports
//   aclk           clock, rising edge
//   areset         asynchronous active-high reset
//   s_axis_tvalid  input word valid
//   s_axis_tready  input word accepted (combinational from m_axis_tready)
//   s_axis_tdata   input word, M_DATA_BITS*RATIO bits
//   s_axis_tlast   input word ends a packet
//   m_axis_tvalid  output beat valid
//   m_axis_tready  downstream accepts beat
//   m_axis_tdata   output beat, M_DATA_BITS bits
//   m_axis_tlast   final beat of a word that arrived with tlast set

module axis_width_down #(
  parameter int unsigned M_DATA_BITS = 32,
  parameter int unsigned RATIO       = 4,
  parameter bit          LSB_FIRST   = 1'b1
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic [M_DATA_BITS*RATIO-1:0]   s_axis_tdata,
  input  logic                           s_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [M_DATA_BITS-1:0]         m_axis_tdata,
  output logic                           m_axis_tlast
);

  localparam int unsigned S_DATA_BITS = M_DATA_BITS * RATIO;
  localparam int unsigned CW          = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST_IDX  = CW'(RATIO - 1);

  // EMPTY <-> valid_q = 0, DRAIN <-> valid_q = 1
  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [S_DATA_BITS-1:0] data_q,  data_d;
  logic                   last_q,  last_d;
  logic [CW-1:0]          cnt_q,   cnt_d;

  logic          valid_q;
  logic          fin;
  logic          s_hs;
  logic          m_hs;
  logic [CW-1:0] sel;

  assign valid_q = (state_q == DRAIN);
  assign fin     = (cnt_q == LAST_IDX);

  assign s_axis_tready = !areset && (!valid_q || (m_axis_tready && fin));
  assign m_axis_tvalid = valid_q;
  assign m_axis_tlast  = valid_q && last_q && fin;

  assign s_hs = s_axis_tvalid && s_axis_tready;
  assign m_hs = m_axis_tvalid && m_axis_tready;

  // Slice select as a compare-and-mux over all slices so RATIO need not be
  // a power of two and no out-of-range part-select can be generated.
  always_comb begin
    sel          = LSB_FIRST ? cnt_q : (LAST_IDX - cnt_q);
    m_axis_tdata = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (sel == CW'(i)) begin
        m_axis_tdata = data_q[i*M_DATA_BITS +: M_DATA_BITS];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      EMPTY: begin
        if (s_hs) begin
          data_d  = s_axis_tdata;
          last_d  = s_axis_tlast;
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (m_hs) begin
          if (!fin) begin
            cnt_d = cnt_q + CW'(1);
          end else if (s_hs) begin
            data_d = s_axis_tdata;
            last_d = s_axis_tlast;
            cnt_d  = '0;
          end else begin
            cnt_d   = '0;
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axis_width_down.sv
module tb_axis_width_down;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT0: 8-bit beats, RATIO 4, LSB first
  logic        s0_valid, s0_ready, s0_last;
  logic [31:0] s0_data;
  logic        m0_valid, m0_ready, m0_last;
  logic [7:0]  m0_data;

  // DUT1: 8-bit beats, RATIO 4, MSB first
  logic        s1_valid, s1_ready, s1_last;
  logic [31:0] s1_data;
  logic        m1_valid, m1_ready, m1_last;
  logic [7:0]  m1_data;

  // DUT2: 32-bit beats, RATIO 1
  logic        s2_valid, s2_ready, s2_last;
  logic [31:0] s2_data;
  logic        m2_valid, m2_ready, m2_last;
  logic [31:0] m2_data;

  axis_width_down #(.M_DATA_BITS(8), .RATIO(4), .LSB_FIRST(1'b1)) u_dut0 (
    .aclk(clk), .areset(rst),
    .s_axis_tvalid(s0_valid), .s_axis_tready(s0_ready),
    .s_axis_tdata(s0_data), .s_axis_tlast(s0_last),
    .m_axis_tvalid(m0_valid), .m_axis_tready(m0_ready),
    .m_axis_tdata(m0_data), .m_axis_tlast(m0_last)
  );

  axis_width_down #(.M_DATA_BITS(8), .RATIO(4), .LSB_FIRST(1'b0)) u_dut1 (
    .aclk(clk), .areset(rst),
    .s_axis_tvalid(s1_valid), .s_axis_tready(s1_ready),
    .s_axis_tdata(s1_data), .s_axis_tlast(s1_last),
    .m_axis_tvalid(m1_valid), .m_axis_tready(m1_ready),
    .m_axis_tdata(m1_data), .m_axis_tlast(m1_last)
  );

  axis_width_down #(.M_DATA_BITS(32), .RATIO(1), .LSB_FIRST(1'b1)) u_dut2 (
    .aclk(clk), .areset(rst),
    .s_axis_tvalid(s2_valid), .s_axis_tready(s2_ready),
    .s_axis_tdata(s2_data), .s_axis_tlast(s2_last),
    .m_axis_tvalid(m2_valid), .m_axis_tready(m2_ready),
    .m_axis_tdata(m2_data), .m_axis_tlast(m2_last)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic        sl;
    logic        mr;
    logic        mv;
    logic [7:0]  md;
    logic        ml;
    logic        sr;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  vec_t  vecs[18];
  beat_t sb[$];

  initial begin
    logic [7:0] exp_msb[4];
    logic [7:0] exp_rst[4];
    beat_t      b;
    logic       held;

    // inputs this cycle | outputs expected this cycle (before the edge)
    vecs[0]  = '{1'b1, 32'h44332211, 1'b1, 1'b1,  1'b0, 8'h00, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b1,  1'b1, 8'h11, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b0,  1'b1, 8'h22, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b0,  1'b1, 8'h22, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b0,  1'b1, 8'h22, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,        1'b0, 1'b1,  1'b1, 8'h22, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b1,  1'b1, 8'h33, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'h88776655, 1'b0, 1'b1,  1'b1, 8'h44, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 32'h04030201, 1'b1, 1'b1,  1'b1, 8'h55, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'h04030201, 1'b1, 1'b1,  1'b1, 8'h66, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 32'h04030201, 1'b1, 1'b1,  1'b1, 8'h77, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 32'h04030201, 1'b1, 1'b1,  1'b1, 8'h88, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 32'h0,        1'b0, 1'b1,  1'b1, 8'h01, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 32'h0,        1'b0, 1'b1,  1'b1, 8'h02, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 32'h0,        1'b0, 1'b1,  1'b1, 8'h03, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 32'h0,        1'b0, 1'b0,  1'b1, 8'h04, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 32'h0,        1'b0, 1'b1,  1'b1, 8'h04, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 32'h0,        1'b0, 1'b1,  1'b0, 8'h00, 1'b0, 1'b1};

    exp_msb[0] = 8'h44; exp_msb[1] = 8'h33; exp_msb[2] = 8'h22; exp_msb[3] = 8'h11;
    exp_rst[0] = 8'hAA; exp_rst[1] = 8'hBB; exp_rst[2] = 8'hCC; exp_rst[3] = 8'hDD;

    rst = 1'b1;
    s0_valid = 1'b0; s0_data = '0; s0_last = 1'b0; m0_ready = 1'b0;
    s1_valid = 1'b0; s1_data = '0; s1_last = 1'b0; m1_ready = 1'b0;
    s2_valid = 1'b0; s2_data = '0; s2_last = 1'b0; m2_ready = 1'b0;

    // ---- reset state ----
    @(negedge clk);
    @(negedge clk);
    #2;
    check("rst_m_valid", m0_valid, 1'b0);
    check("rst_m_last",  m0_last,  1'b0);
    check("rst_m_data",  m0_data,  8'h00);
    check("rst_s_ready", s0_ready, 1'b0);
    check("rst_s_ready_r1", s2_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("post_rst_s_ready", s0_ready, 1'b1);
    check("post_rst_m_valid", m0_valid, 1'b0);

    // ---- table: single word, backpressure, back-to-back, final-beat stall ----
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      s0_valid = vecs[i].sv;
      s0_data  = vecs[i].sd;
      s0_last  = vecs[i].sl;
      m0_ready = vecs[i].mr;
      #2;
      check($sformatf("vec%0d_m_valid", i), m0_valid, vecs[i].mv);
      check($sformatf("vec%0d_m_last", i),  m0_last,  vecs[i].ml);
      check($sformatf("vec%0d_s_ready", i), s0_ready, vecs[i].sr);
      if (vecs[i].mv)
        check($sformatf("vec%0d_m_data", i), m0_data, vecs[i].md);
    end

    // ---- reset mid-word ----
    @(negedge clk);
    s0_valid = 1'b1; s0_data = 32'h44332211; s0_last = 1'b1; m0_ready = 1'b1;
    #2;
    check("mid_accept_ready", s0_ready, 1'b1);
    @(negedge clk);
    s0_valid = 1'b0;
    #2;
    check("mid_beat0", m0_data, 8'h11);
    @(negedge clk);
    #2;
    check("mid_beat1", m0_data, 8'h22);
    @(negedge clk);
    #2;
    check("mid_beat2", m0_data, 8'h33);
    rst = 1'b1;
    #1;
    check("mid_rst_m_valid", m0_valid, 1'b0);
    check("mid_rst_m_last",  m0_last,  1'b0);
    check("mid_rst_m_data",  m0_data,  8'h00);
    check("mid_rst_s_ready", s0_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("mid_rel_s_ready", s0_ready, 1'b1);
    check("mid_rel_m_valid", m0_valid, 1'b0);
    @(negedge clk);
    s0_valid = 1'b1; s0_data = 32'hDDCCBBAA; s0_last = 1'b1;
    #2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s0_valid = 1'b0;
      #2;
      check($sformatf("after_rst_valid%0d", k), m0_valid, 1'b1);
      check($sformatf("after_rst_data%0d", k),  m0_data,  exp_rst[k]);
      check($sformatf("after_rst_last%0d", k),  m0_last,  (k == 3));
    end

    // ---- MSB-first ordering ----
    @(negedge clk);
    s1_valid = 1'b1; s1_data = 32'h44332211; s1_last = 1'b1; m1_ready = 1'b1;
    #2;
    check("msb_accept_ready", s1_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s1_valid = 1'b0;
      #2;
      check($sformatf("msb_valid%0d", k), m1_valid, 1'b1);
      check($sformatf("msb_data%0d", k),  m1_data,  exp_msb[k]);
      check($sformatf("msb_last%0d", k),  m1_last,  (k == 3));
    end
    @(negedge clk);
    #2;
    check("msb_idle_valid", m1_valid, 1'b0);

    // ---- RATIO=1 random traffic against a scoreboard ----
    held = 1'b0;
    for (int c = 0; c < 1020; c++) begin
      @(negedge clk);
      if (c < 1000) begin
        if (!held) begin
          s2_valid = ($urandom_range(0, 3) != 0);
          s2_data  = $urandom;
          s2_last  = $urandom_range(0, 1);
        end
        m2_ready = ($urandom_range(0, 3) != 0);
      end else begin
        s2_valid = 1'b0;
        m2_ready = 1'b1;
      end
      #2;
      held = s2_valid && !s2_ready;
      if (m2_ready)
        check("r1_ready_passthru", s2_ready, 1'b1);
      if (m2_valid && m2_ready) begin
        if (sb.size() == 0) begin
          check("r1_unexpected_beat", 1'b1, 1'b0);
        end else begin
          b = sb.pop_front();
          check("r1_data", m2_data, b.d);
          check("r1_last", m2_last, b.l);
        end
      end
      if (s2_valid && s2_ready)
        sb.push_back('{d: s2_data, l: s2_last});
    end
    check("r1_drained", sb.size(), 0);

    // ---- RATIO=1 full throughput with both sides continuously ready ----
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      s2_valid = (c < 20);
      s2_data  = 32'hA5000000 + c;
      s2_last  = c[0];
      m2_ready = 1'b1;
      #2;
      if (c >= 1 && c <= 20)
        check("r1_stream_valid", m2_valid, 1'b1);
      if (m2_valid && m2_ready) begin
        if (sb.size() == 0) begin
          check("r1_stream_unexpected", 1'b1, 1'b0);
        end else begin
          b = sb.pop_front();
          check("r1_stream_data", m2_data, b.d);
          check("r1_stream_last", m2_last, b.l);
        end
      end
      if (s2_valid && s2_ready)
        sb.push_back('{d: s2_data, l: s2_last});
    end
    check("r1_stream_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
